parallel_threshold_ctrl: RTL and testbench
==========================================

PARALLEL_THRESHOLD_CTRL -- requirements
Module: parallel_threshold_ctrl

Interface
REQ-001 Parameter NUM_LANES, default 4, number of worker lanes (1..8).
REQ-002 Parameter X_BITS, default 8, output column width; Y_BITS, default 8, output row width.
REQ-003 Parameter C_BITS, default 5, threshold-offset width; CYCLE_BITS, default 24, cycle counter width.
REQ-004 Parameter LAUNCH_GAP, default 2, cycles between successive lane enables (>=1).
REQ-005 clock  in  1  clock; all state on rising edge.
REQ-006 not_reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle run request.
REQ-008 c_in  in  C_BITS  threshold offset, sampled at accepted start; invert_in  in  1  polarity mode, sampled at accepted start.
REQ-009 lane_en  out  NUM_LANES  per-lane enable, held high from launch until DONE.
REQ-010 lane_done  in  NUM_LANES  per-lane level "lane finished".
REQ-011 lane_wr_valid  in  NUM_LANES; lane_wr_x  in  NUM_LANES*X_BITS; lane_wr_y  in  NUM_LANES*Y_BITS; lane_wr_bit  in  NUM_LANES  per-lane result write offers; lane i occupies slice i.
REQ-012 lane_wr_ready  out  NUM_LANES  per-lane grant; transfer on valid&ready.
REQ-013 oX  out  X_BITS; oY  out  Y_BITS; oPix  out  1; oWren  out  1  registered output write port.
REQ-014 c_out  out  C_BITS  latched offset driven to lanes.
REQ-015 invert_out  out  1  latched polarity mode.
REQ-016 state_onehot  out  5  {DONE,DRAIN,RUN,LAUNCH,IDLE} one-hot status for LEDs.
REQ-017 cycle_count  out  CYCLE_BITS  run length counter.

Function
REQ-018 FSM states IDLE, LAUNCH, RUN, DRAIN, DONE; exactly one state_onehot bit high at all times.
REQ-019 IDLE: start=1 -> latch c_in, invert_in; clear cycle_count; enter LAUNCH next cycle.
REQ-020 start in any state other than IDLE/DONE is ignored; start in DONE behaves as in IDLE (clears lane_en first cycle).
REQ-021 LAUNCH: lane 0 enabled on first LAUNCH cycle; lane k enabled k*LAUNCH_GAP cycles later; after last lane enabled -> RUN.
REQ-022 NUM_LANES=1: LAUNCH lasts exactly one cycle.
REQ-023 RUN: when lane_done all ones -> DRAIN.
REQ-024 DRAIN: when no lane_wr_valid high and output register empty (oWren=0 next) -> DONE.
REQ-025 DONE: lane_en all zero; hold until start.
REQ-026 cycle_count increments by 1 every cycle in LAUNCH, RUN, DRAIN; saturates at all-ones; holds in IDLE/DONE.
REQ-027 Arbiter: round-robin over lanes with valid and lane_en high; at most one lane_wr_ready bit per cycle; search starts at lane after last granted.
REQ-028 lane_wr_ready combinational from valid and pointer; a lane with valid held high is granted within NUM_LANES cycles.
REQ-029 Granted transfer appears on oX/oY one cycle later with oWren=1; oPix = lane_wr_bit ^ invert_out.
REQ-030 No transfer -> oWren=0 next cycle; oX/oY/oPix hold last values.
REQ-031 Valid from a lane whose lane_en=0 is never granted.
REQ-032 Grants permitted in LAUNCH, RUN, DRAIN; none in IDLE/DONE.

Reset
REQ-033 not_reset low -> state IDLE, lane_en=0, lane_wr_ready=0, oWren=0, oX=oY=0, oPix=0, c_out=0, invert_out=0, cycle_count=0, arbiter pointer=lane 0, immediately and asynchronously.
REQ-034 Reset mid-run abandons operation; no output write until next accepted start.

Verification
REQ-035 NUM_LANES=4, LAUNCH_GAP=2, start, c_in=5'd7 -> lane_en bits rise at cycles 1,3,5,7 after start; c_out=7; state_onehot LAUNCH->RUN.
REQ-036 Lanes 0,2,3 hold valid continuously -> grants 0,2,3,0,2,3...; each grant reproduced on oX/oY one cycle later with oWren=1.
REQ-037 invert_in=1 at start, lane_wr_bit=1 -> oPix=0; invert_in=0 -> oPix=1.
REQ-038 All lane_done high while lane 1 valid pending -> DRAIN until lane 1 transfers, then DONE; lane_en=0; cycle_count frozen at run length.
REQ-039 Start pulsed during RUN -> ignored, c_out unchanged; not_reset low during RUN -> all outputs at reset values same cycle.
REQ-040 CYCLE_BITS=4 with run >15 cycles -> cycle_count holds 4'hF.

Source files
------------

// File: rtl/parallel_threshold_ctrl.sv
// Parallel threshold controller: launches NUM_LANES workers staggered by LAUNCH_GAP cycles and
// merges their pixel writes round-robin into one registered write port (1-cycle grant-to-write).
module parallel_threshold_ctrl #(
    parameter int NUM_LANES  = 4,
    parameter int X_BITS     = 8,
    parameter int Y_BITS     = 8,
    parameter int C_BITS     = 5,
    parameter int CYCLE_BITS = 24,
    parameter int LAUNCH_GAP = 2
) (
    input  logic                        clock,
    input  logic                        not_reset,
    input  logic                        start,
    input  logic [C_BITS-1:0]           c_in,
    input  logic                        invert_in,
    output logic [NUM_LANES-1:0]        lane_en,
    input  logic [NUM_LANES-1:0]        lane_done,
    input  logic [NUM_LANES-1:0]        lane_wr_valid,
    input  logic [NUM_LANES*X_BITS-1:0] lane_wr_x,
    input  logic [NUM_LANES*Y_BITS-1:0] lane_wr_y,
    input  logic [NUM_LANES-1:0]        lane_wr_bit,
    output logic [NUM_LANES-1:0]        lane_wr_ready,
    output logic [X_BITS-1:0]           oX,
    output logic [Y_BITS-1:0]           oY,
    output logic                        oPix,
    output logic                        oWren,
    output logic [C_BITS-1:0]           c_out,
    output logic                        invert_out,
    output logic [4:0]                  state_onehot,
    output logic [CYCLE_BITS-1:0]       cycle_count
);
    localparam int PW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int LW = $clog2(NUM_LANES + 1);
    localparam int GW = (LAUNCH_GAP > 1) ? $clog2(LAUNCH_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            active;
    logic            launch_last;
    logic [LW-1:0]   next_lane;
    logic [GW-1:0]   gap_cnt;
    logic [NUM_LANES-1:0] req;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   scan_idx;
    logic            grant_found;

    assign accept      = start && (state == IDLE || state == DONE);
    assign active      = (state == LAUNCH) || (state == RUN) || (state == DRAIN);
    assign launch_last = (next_lane == LW'(NUM_LANES));
    assign req         = lane_wr_valid & lane_en & {NUM_LANES{active}};

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LAUNCH;
            LAUNCH:  if (launch_last) state_next = RUN;
            RUN:     if (&lane_done) state_next = DRAIN;
            DRAIN:   if (req == '0) state_next = DONE;
            DONE:    if (start) state_next = LAUNCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        state_onehot = 5'b00001;
        case (state)
            IDLE:    state_onehot = 5'b00001;
            LAUNCH:  state_onehot = 5'b00010;
            RUN:     state_onehot = 5'b00100;
            DRAIN:   state_onehot = 5'b01000;
            DONE:    state_onehot = 5'b10000;
            default: state_onehot = 5'b00001;
        endcase
    end

    // Lane 0 comes up with the accept edge; each further lane after LAUNCH_GAP more cycles.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            lane_en   <= '0;
            next_lane <= '0;
            gap_cnt   <= '0;
        end else if (accept) begin
            lane_en   <= NUM_LANES'(1);
            next_lane <= LW'(1);
            gap_cnt   <= '0;
        end else if (state_next == DONE) begin
            lane_en   <= '0;
        end else if (state == LAUNCH && !launch_last) begin
            if (gap_cnt == GW'(LAUNCH_GAP - 1)) begin
                lane_en   <= lane_en | (NUM_LANES'(1) << next_lane);
                next_lane <= next_lane + LW'(1);
                gap_cnt   <= '0;
            end else begin
                gap_cnt   <= gap_cnt + GW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            c_out       <= '0;
            invert_out  <= 1'b0;
            cycle_count <= '0;
        end else if (accept) begin
            c_out       <= c_in;
            invert_out  <= invert_in;
            cycle_count <= '0;
        end else if (active && !(&cycle_count)) begin
            cycle_count <= cycle_count + CYCLE_BITS'(1);
        end
    end

    // Search begins at the lane after the previous winner, so a held request waits at most NUM_LANES cycles.
    always_comb begin
        lane_wr_ready = '0;
        grant_idx     = '0;
        grant_found   = 1'b0;
        scan_idx      = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            scan_idx = PW'((int'(ptr) + k) % NUM_LANES);
            if (!grant_found && req[scan_idx]) begin
                grant_found             = 1'b1;
                lane_wr_ready[scan_idx] = 1'b1;
                grant_idx               = scan_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            ptr   <= '0;
            oX    <= '0;
            oY    <= '0;
            oPix  <= 1'b0;
            oWren <= 1'b0;
        end else begin
            oWren <= grant_found;
            if (grant_found) begin
                ptr  <= (int'(grant_idx) == NUM_LANES - 1) ? '0 : grant_idx + PW'(1);
                oX   <= lane_wr_x[grant_idx*X_BITS +: X_BITS];
                oY   <= lane_wr_y[grant_idx*Y_BITS +: Y_BITS];
                oPix <= lane_wr_bit[grant_idx] ^ invert_out;
            end
        end
    end
endmodule

// File: tb/tb_parallel_threshold_ctrl.sv
// Directed bench for parallel_threshold_ctrl; a second instance with a 4-bit cycle counter shares the stimulus.
module tb_parallel_threshold_ctrl;
    localparam int N = 4;

    logic           clock = 1'b0;
    logic           not_reset = 1'b0;
    logic           start = 1'b0;
    logic [4:0]     c_in = '0;
    logic           invert_in = 1'b0;
    logic [N-1:0]   lane_done = '0;
    logic [N-1:0]   lane_wr_valid = '0;
    logic [N-1:0]   lane_wr_bit = '0;
    logic [N*8-1:0] lane_wr_x = '0;
    logic [N*8-1:0] lane_wr_y = '0;

    logic [N-1:0]   lane_en, lane_wr_ready;
    logic [7:0]     oX, oY;
    logic           oPix, oWren, invert_out;
    logic [4:0]     c_out, state_onehot;
    logic [23:0]    cycle_count;

    logic [N-1:0]   s_lane_en, s_lane_wr_ready;
    logic [7:0]     s_oX, s_oY;
    logic           s_oPix, s_oWren, s_invert_out;
    logic [4:0]     s_c_out, s_state_onehot;
    logic [3:0]     s_cycle_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    parallel_threshold_ctrl dut (
        .clock(clock), .not_reset(not_reset), .start(start), .c_in(c_in), .invert_in(invert_in),
        .lane_en(lane_en), .lane_done(lane_done), .lane_wr_valid(lane_wr_valid),
        .lane_wr_x(lane_wr_x), .lane_wr_y(lane_wr_y), .lane_wr_bit(lane_wr_bit),
        .lane_wr_ready(lane_wr_ready), .oX(oX), .oY(oY), .oPix(oPix), .oWren(oWren),
        .c_out(c_out), .invert_out(invert_out), .state_onehot(state_onehot),
        .cycle_count(cycle_count)
    );

    parallel_threshold_ctrl #(.CYCLE_BITS(4)) u_sat (
        .clock(clock), .not_reset(not_reset), .start(start), .c_in(c_in), .invert_in(invert_in),
        .lane_en(s_lane_en), .lane_done(lane_done), .lane_wr_valid(lane_wr_valid),
        .lane_wr_x(lane_wr_x), .lane_wr_y(lane_wr_y), .lane_wr_bit(lane_wr_bit),
        .lane_wr_ready(s_lane_wr_ready), .oX(s_oX), .oY(s_oY), .oPix(s_oPix), .oWren(s_oWren),
        .c_out(s_c_out), .invert_out(s_invert_out), .state_onehot(s_state_onehot),
        .cycle_count(s_cycle_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        lane_wr_valid = '1;
        #2;
        checks++; if (state_onehot !== 5'b00001) begin errors++; $display("FAIL reset_state got %b exp 00001", state_onehot); end
        checks++; if (lane_en !== 4'b0000) begin errors++; $display("FAIL reset_lane_en got %b exp 0000", lane_en); end
        checks++; if (lane_wr_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", lane_wr_ready); end
        checks++; if ({oWren, oPix, oX, oY} !== 18'h0) begin errors++; $display("FAIL reset_outport got %h exp 0", {oWren, oPix, oX, oY}); end
        checks++; if ({c_out, invert_out} !== 6'h0) begin errors++; $display("FAIL reset_latches got %h exp 0", {c_out, invert_out}); end
        checks++; if (cycle_count !== 24'h0) begin errors++; $display("FAIL reset_cycle_count got %h exp 0", cycle_count); end
        lane_wr_valid = '0;
        tick();
        not_reset = 1'b1;
        tick();
    endtask

    // Start with c_in=7, invert=1; lane k rises at cycle 1+2k, RUN from cycle 8.
    task automatic test_launch;
        logic [N-1:0] exp_en;
        logic [4:0]   exp_st;
        c_in = 5'd7;
        invert_in = 1'b1;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        c_in = 5'd0;
        invert_in = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_en = '0;
            for (int k = 0; k < N; k++) if (1 + 2 * k <= c) exp_en[k] = 1'b1;
            exp_st = (c <= 7) ? 5'b00010 : 5'b00100;
            checks++; if (lane_en !== exp_en) begin errors++; $display("FAIL launch_lane_en c%0d got %b exp %b", c, lane_en, exp_en); end
            checks++; if (state_onehot !== exp_st) begin errors++; $display("FAIL launch_state c%0d got %b exp %b", c, state_onehot, exp_st); end
            checks++; if (cycle_count !== 24'(c - 1)) begin errors++; $display("FAIL launch_cycle_count c%0d got %0d exp %0d", c, cycle_count, c - 1); end
            checks++; if (s_cycle_count !== 4'(c - 1)) begin errors++; $display("FAIL launch_sat_count c%0d got %0d exp %0d", c, s_cycle_count, c - 1); end
            if (c == 2) begin
                lane_wr_valid = 4'b1000;
                #1;
                checks++; if (lane_wr_ready !== 4'b0000) begin errors++; $display("FAIL disabled_lane_grant got %b exp 0000", lane_wr_ready); end
                lane_wr_valid = '0;
            end
            if (c < 8) tick();
        end
        checks++; if (c_out !== 5'd7) begin errors++; $display("FAIL launch_c_out got %0d exp 7", c_out); end
        checks++; if (invert_out !== 1'b1) begin errors++; $display("FAIL launch_invert got %b exp 1", invert_out); end
    endtask

    task automatic test_round_robin;
        int seq [6] = '{0, 2, 3, 0, 2, 3};
        int l;
        for (int i = 0; i < N; i++) begin
            lane_wr_x[i*8 +: 8] = 8'(16 + i);
            lane_wr_y[i*8 +: 8] = 8'(32 + i);
        end
        lane_wr_bit = '1;
        lane_wr_valid = 4'b1101;
        #1;
        for (int j = 0; j < 6; j++) begin
            l = seq[j];
            checks++; if (lane_wr_ready !== 4'(1 << l)) begin errors++; $display("FAIL rr_grant %0d got %b exp lane %0d", j, lane_wr_ready, l); end
            tick();
            checks++; if ({oWren, oX, oY} !== {1'b1, 8'(16 + l), 8'(32 + l)}) begin errors++; $display("FAIL rr_write %0d got wren=%b x=%h y=%h exp lane %0d", j, oWren, oX, oY, l); end
            checks++; if (oPix !== 1'b0) begin errors++; $display("FAIL rr_pix_inverted %0d got %b exp 0", j, oPix); end
        end
        lane_wr_valid = '0;
        tick();
        checks++; if ({oWren, oX, oY, oPix} !== {1'b0, 8'h13, 8'h23, 1'b0}) begin errors++; $display("FAIL idle_hold got wren=%b x=%h y=%h exp 0/13/23", oWren, oX, oY); end
    endtask

    task automatic test_start_ignored;
        c_in = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (c_out !== 5'd7) begin errors++; $display("FAIL run_start_c_out got %0d exp 7", c_out); end
        checks++; if (state_onehot !== 5'b00100) begin errors++; $display("FAIL run_start_state got %b exp 00100", state_onehot); end
    endtask

    task automatic test_drain;
        lane_done = '1;
        lane_wr_valid = 4'b0011;
        #1;
        checks++; if (lane_wr_ready !== 4'b0001) begin errors++; $display("FAIL drain_first_grant got %b exp 0001", lane_wr_ready); end
        tick();
        lane_wr_valid = 4'b0010;
        #1;
        checks++; if (state_onehot !== 5'b01000) begin errors++; $display("FAIL drain_enter got %b exp 01000", state_onehot); end
        checks++; if (lane_wr_ready !== 4'b0010) begin errors++; $display("FAIL drain_lane1_grant got %b exp 0010", lane_wr_ready); end
        tick();
        lane_wr_valid = '0;
        #1;
        checks++; if ({state_onehot, lane_en} !== {5'b01000, 4'b1111}) begin errors++; $display("FAIL drain_hold got st=%b en=%b exp 01000/1111", state_onehot, lane_en); end
        checks++; if ({oWren, oX, oPix} !== {1'b1, 8'h11, 1'b0}) begin errors++; $display("FAIL drain_write got wren=%b x=%h pix=%b exp 1/11/0", oWren, oX, oPix); end
        tick();
        checks++; if ({state_onehot, lane_en, oWren} !== {5'b10000, 4'b0000, 1'b0}) begin errors++; $display("FAIL done_state got st=%b en=%b wren=%b", state_onehot, lane_en, oWren); end
        checks++; if (cycle_count !== 24'(cyc - 1)) begin errors++; $display("FAIL done_run_length got %0d exp %0d", cycle_count, cyc - 1); end
        checks++; if (s_cycle_count !== 4'hF) begin errors++; $display("FAIL saturate got %h exp F", s_cycle_count); end
        lane_done = '0;
        tick();
        checks++; if (cycle_count !== 24'(cyc - 2)) begin errors++; $display("FAIL done_frozen got %0d exp %0d", cycle_count, cyc - 2); end
    endtask

    task automatic test_invert_zero;
        c_in = 5'd21;
        invert_in = 1'b0;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        checks++; if ({c_out, invert_out} !== {5'd21, 1'b0}) begin errors++; $display("FAIL restart_latch got c=%0d inv=%b exp 21/0", c_out, invert_out); end
        checks++; if ({state_onehot, lane_en} !== {5'b00010, 4'b0001}) begin errors++; $display("FAIL restart_launch got st=%b en=%b", state_onehot, lane_en); end
        checks++; if (cycle_count !== 24'h0) begin errors++; $display("FAIL restart_count got %0d exp 0", cycle_count); end
        lane_wr_valid = 4'b0001;
        #1;
        checks++; if (lane_wr_ready !== 4'b0001) begin errors++; $display("FAIL launch_grant got %b exp 0001", lane_wr_ready); end
        tick();
        lane_wr_valid = '0;
        checks++; if ({oWren, oX, oPix} !== {1'b1, 8'h10, 1'b1}) begin errors++; $display("FAIL pix_plain got wren=%b x=%h pix=%b exp 1/10/1", oWren, oX, oPix); end
    endtask

    task automatic test_reset_midrun;
        while (cyc < 8) tick();
        checks++; if (state_onehot !== 5'b00100) begin errors++; $display("FAIL midrun_state got %b exp 00100", state_onehot); end
        lane_wr_valid = 4'b0001;
        tick();
        checks++; if (oWren !== 1'b1) begin errors++; $display("FAIL midrun_write got %b exp 1", oWren); end
        start = 1'b1;
        #2;
        not_reset = 1'b0;
        #1;
        checks++; if ({state_onehot, lane_en, lane_wr_ready} !== {5'b00001, 4'b0000, 4'b0000}) begin errors++; $display("FAIL async_reset_ctrl got st=%b en=%b rdy=%b", state_onehot, lane_en, lane_wr_ready); end
        checks++; if ({oWren, oPix, oX, oY, c_out, invert_out, cycle_count} !== 48'h0) begin errors++; $display("FAIL async_reset_data got wren=%b x=%h c=%0d cnt=%0d", oWren, oX, c_out, cycle_count); end
        start = 1'b0;
        not_reset = 1'b1;
        tick();
        tick();
        checks++; if ({state_onehot, oWren, lane_wr_ready} !== {5'b00001, 1'b0, 4'b0000}) begin errors++; $display("FAIL post_reset_quiet got st=%b wren=%b rdy=%b", state_onehot, oWren, lane_wr_ready); end
        lane_wr_valid = '0;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_round_robin();
        test_start_ignored();
        test_drain();
        test_invert_zero();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
